// File: rtl/time_set_ctrl_if.sv
// Button, live-time and load-bus signals between the time-set controller and its
// surroundings (button synchronizers, downstream hh:mm:ss counter).
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_cancel;
    logic [4:0] hours_cur;
    logic [5:0] mins_cur;
    logic [5:0] secs_cur;
    logic [4:0] hours_o;
    logic [5:0] mins_o;
    logic [5:0] secs_o;
    logic       start;
    logic       edit_active;
    logic [1:0] field_sel;

    modport master (
        output btn_mode, btn_inc, btn_dec, btn_cancel,
        output hours_cur, mins_cur, secs_cur,
        input  hours_o, mins_o, secs_o, start, edit_active, field_sel
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, btn_cancel,
        input  hours_cur, mins_cur, secs_cur,
        output hours_o, mins_o, secs_o, start, edit_active, field_sel
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Button-driven editor for an hh:mm:ss counter: edits hours, minutes, seconds in turn
// and issues a one-cycle load strobe on commit.
module time_set_ctrl #(
    parameter int HOUR_MOD  = 24,
    parameter bit SEED_LIVE = 1'b1
) (
    input logic           clk,
    input logic           reset,
    time_set_ctrl_if.slave bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_EDIT_H = 3'd1;
    localparam logic [2:0] ST_EDIT_M = 3'd2;
    localparam logic [2:0] ST_EDIT_S = 3'd3;
    localparam logic [2:0] ST_COMMIT = 3'd4;

    localparam logic [4:0] H_MAX  = 5'(HOUR_MOD - 1);
    localparam logic [5:0] H_MOD6 = 6'(HOUR_MOD);
    localparam logic [5:0] S_MAX  = 6'd59;

    logic [2:0] state, state_nxt;
    logic [3:0] btn_hist;
    logic [3:0] btn_now;
    logic [3:0] btn_edge;
    logic       cancel_e, mode_e, inc_e, dec_e;
    logic [4:0] hours_r, hours_nxt;
    logic [5:0] mins_r, mins_nxt;
    logic [5:0] secs_r, secs_nxt;

    function automatic logic [4:0] step_hour(input logic [4:0] v, input logic up);
        if (up) step_hour = (v >= H_MAX) ? 5'd0 : v + 5'd1;
        else    step_hour = (v == 5'd0) ? H_MAX : v - 5'd1;
    endfunction

    function automatic logic [5:0] step_sixty(input logic [5:0] v, input logic up);
        if (up) step_sixty = (v >= S_MAX) ? 6'd0 : v + 6'd1;
        else    step_sixty = (v == 6'd0) ? S_MAX : v - 6'd1;
    endfunction

    function automatic logic [5:0] clamp_sixty(input logic [5:0] v);
        clamp_sixty = (v > S_MAX) ? 6'd0 : v;
    endfunction

    // History resets to all-ones so a button held through reset release is not an edge.
    assign btn_now  = {bus.btn_cancel, bus.btn_mode, bus.btn_inc, bus.btn_dec};
    assign btn_edge = btn_now & ~btn_hist;
    assign cancel_e = btn_edge[3];
    assign mode_e   = btn_edge[2];
    assign inc_e    = btn_edge[1];
    assign dec_e    = btn_edge[0];

    always_comb begin
        state_nxt = state;
        hours_nxt = hours_r;
        mins_nxt  = mins_r;
        secs_nxt  = secs_r;
        case (state)
            ST_IDLE: begin
                if (mode_e) begin
                    state_nxt = ST_EDIT_H;
                    if (SEED_LIVE) begin
                        hours_nxt = ({1'b0, bus.hours_cur} >= H_MOD6) ? 5'd0 : bus.hours_cur;
                        mins_nxt  = clamp_sixty(bus.mins_cur);
                        secs_nxt  = clamp_sixty(bus.secs_cur);
                    end else begin
                        hours_nxt = 5'd0;
                        mins_nxt  = 6'd0;
                        secs_nxt  = 6'd0;
                    end
                end
            end
            ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
                if (cancel_e) begin
                    state_nxt = ST_IDLE;
                end else if (mode_e) begin
                    state_nxt = state + 3'd1;
                end else if (inc_e ^ dec_e) begin
                    // Simultaneous inc and dec cancel out; otherwise step the selected field.
                    if (state == ST_EDIT_H)      hours_nxt = step_hour(hours_r, inc_e);
                    else if (state == ST_EDIT_M) mins_nxt  = step_sixty(mins_r, inc_e);
                    else                         secs_nxt  = step_sixty(secs_r, inc_e);
                end
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            btn_hist <= 4'hF;
            hours_r  <= 5'd0;
            mins_r   <= 6'd0;
            secs_r   <= 6'd0;
        end else begin
            state    <= state_nxt;
            btn_hist <= btn_now;
            hours_r  <= hours_nxt;
            mins_r   <= mins_nxt;
            secs_r   <= secs_nxt;
        end
    end

    // Status outputs decode from the state register only.
    always_comb begin
        bus.field_sel = 2'b00;
        case (state)
            ST_EDIT_H: bus.field_sel = 2'b01;
            ST_EDIT_M: bus.field_sel = 2'b10;
            ST_EDIT_S: bus.field_sel = 2'b11;
            default:   bus.field_sel = 2'b00;
        endcase
    end

    assign bus.start       = (state == ST_COMMIT);
    assign bus.edit_active = (state == ST_EDIT_H) || (state == ST_EDIT_M) || (state == ST_EDIT_S);
    assign bus.hours_o     = hours_r;
    assign bus.mins_o      = mins_r;
    assign bus.secs_o      = secs_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus random button traffic,
// compared each cycle against a press-level reference model.
module tb_time_set_ctrl;

    localparam int HM = 24;

    logic clk = 1'b0;
    logic reset = 1'b1;
    time_set_ctrl_if bus_if ();

    time_set_ctrl #(.HOUR_MOD(HM), .SEED_LIVE(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int last_h = 0, last_m = 0, last_s = 0;

    // Reference model: phase 0 idle, 1..3 editing field phase-1, 4 commit.
    int m_phase;
    int m_f[3];
    int m_mod[3];
    bit m_prev[4];   // cancel, mode, inc, dec

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        for (int i = 0; i < 3; i++) m_f[i] = 0;
        for (int i = 0; i < 4; i++) m_prev[i] = 1'b1;
    endtask

    task automatic model_step(input bit c, input bit md, input bit in, input bit dc);
        bit ec, em, ei, ed;
        int cur[3];
        ec = c && !m_prev[0];
        em = md && !m_prev[1];
        ei = in && !m_prev[2];
        ed = dc && !m_prev[3];
        m_prev[0] = c; m_prev[1] = md; m_prev[2] = in; m_prev[3] = dc;
        cur[0] = int'(bus_if.hours_cur);
        cur[1] = int'(bus_if.mins_cur);
        cur[2] = int'(bus_if.secs_cur);
        if (m_phase == 0) begin
            if (em) begin
                m_phase = 1;
                for (int i = 0; i < 3; i++) m_f[i] = (cur[i] >= m_mod[i]) ? 0 : cur[i];
            end
        end else if (m_phase == 4) begin
            m_phase = 0;
        end else begin
            if (ec) m_phase = 0;
            else if (em) m_phase = m_phase + 1;
            else if (ei && !ed) m_f[m_phase-1] = (m_f[m_phase-1] + 1) % m_mod[m_phase-1];
            else if (ed && !ei) m_f[m_phase-1] = (m_f[m_phase-1] + m_mod[m_phase-1] - 1) % m_mod[m_phase-1];
        end
    endtask

    task automatic check_all(input string tag);
        int exp_sel;
        exp_sel = (m_phase >= 1 && m_phase <= 3) ? m_phase : 0;
        chk({tag, ".hours"}, int'(bus_if.hours_o), m_f[0]);
        chk({tag, ".mins"},  int'(bus_if.mins_o),  m_f[1]);
        chk({tag, ".secs"},  int'(bus_if.secs_o),  m_f[2]);
        chk({tag, ".start"}, int'(bus_if.start), (m_phase == 4) ? 1 : 0);
        chk({tag, ".edit"},  int'(bus_if.edit_active), (exp_sel != 0) ? 1 : 0);
        chk({tag, ".sel"},   int'(bus_if.field_sel), exp_sel);
    endtask

    // b = {cancel, mode, inc, dec}
    task automatic cyc(input logic [3:0] b, input string tag);
        bus_if.btn_cancel = b[3];
        bus_if.btn_mode   = b[2];
        bus_if.btn_inc    = b[1];
        bus_if.btn_dec    = b[0];
        @(posedge clk);
        if (reset) model_reset();
        else model_step(b[3], b[2], b[1], b[0]);
        #1;
        check_all(tag);
        if (bus_if.start === 1'b1) begin
            start_cnt++;
            last_h = int'(bus_if.hours_o);
            last_m = int'(bus_if.mins_o);
            last_s = int'(bus_if.secs_o);
        end
    endtask

    task automatic press(input logic [3:0] b, input string tag);
        cyc(b, tag);
        cyc(4'b0000, tag);
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        bus_if.hours_cur = 5'(h);
        bus_if.mins_cur  = 6'(m);
        bus_if.secs_cur  = 6'(s);
    endtask

    localparam logic [3:0] B_CAN = 4'b1000;
    localparam logic [3:0] B_MOD = 4'b0100;
    localparam logic [3:0] B_INC = 4'b0010;
    localparam logic [3:0] B_DEC = 4'b0001;

    initial begin
        int s0;
        m_mod[0] = HM; m_mod[1] = 60; m_mod[2] = 60;
        model_reset();
        bus_if.btn_cancel = 1'b0;
        bus_if.btn_mode   = 1'b0;
        bus_if.btn_inc    = 1'b0;
        bus_if.btn_dec    = 1'b0;
        set_cur(13, 45, 30);

        // Reset state
        #12;
        check_all("reset");
        reset = 1'b0;
        cyc(4'b0000, "idle");

        // Full edit sequence from live 13:45:30
        s0 = start_cnt;
        press(B_MOD, "seq.enter");
        chk("seq.enter_h", int'(bus_if.hours_o), 13);
        press(B_INC, "seq.inc1");
        press(B_INC, "seq.inc2");
        press(B_MOD, "seq.to_m");
        press(B_DEC, "seq.dec");
        press(B_MOD, "seq.to_s");
        press(B_MOD, "seq.commit");
        chk("seq.pulses", start_cnt - s0, 1);
        chk("seq.h", last_h, 15);
        chk("seq.m", last_m, 44);
        chk("seq.s", last_s, 30);
        chk("seq.idle_sel", int'(bus_if.field_sel), 0);

        // Wrap boundaries
        set_cur(23, 0, 59);
        press(B_MOD, "wrap.enter");
        press(B_INC, "wrap.h");
        chk("wrap.h23_inc", int'(bus_if.hours_o), 0);
        press(B_MOD, "wrap.to_m");
        press(B_DEC, "wrap.m");
        chk("wrap.m0_dec", int'(bus_if.mins_o), 59);
        press(B_MOD, "wrap.to_s");
        press(B_INC, "wrap.s");
        chk("wrap.s59_inc", int'(bus_if.secs_o), 0);
        press(B_DEC, "wrap.s_back");
        chk("wrap.s0_dec", int'(bus_if.secs_o), 59);
        s0 = start_cnt;
        press(B_CAN, "wrap.cancel");
        chk("wrap.cancel_nostart", start_cnt - s0, 0);

        // Out-of-range capture
        set_cur(25, 61, 7);
        press(B_MOD, "clamp.enter");
        chk("clamp.h", int'(bus_if.hours_o), 0);
        chk("clamp.m", int'(bus_if.mins_o), 0);
        chk("clamp.s", int'(bus_if.secs_o), 7);
        press(B_CAN, "clamp.cancel");

        // Cancel with inc in EDIT_M
        set_cur(8, 20, 10);
        press(B_MOD, "ci.enter");
        press(B_MOD, "ci.to_m");
        s0 = start_cnt;
        press(B_CAN | B_INC, "ci.both");
        chk("ci.mins", int'(bus_if.mins_o), 20);
        chk("ci.sel", int'(bus_if.field_sel), 0);
        chk("ci.nostart", start_cnt - s0, 0);

        // Priority checks: mode+inc advances only, inc+dec no change
        press(B_MOD, "pr.enter");
        press(B_INC | B_DEC, "pr.incdec");
        chk("pr.incdec_h", int'(bus_if.hours_o), 8);
        press(B_MOD | B_INC, "pr.modinc");
        chk("pr.modinc_h", int'(bus_if.hours_o), 8);
        chk("pr.modinc_sel", int'(bus_if.field_sel), 2);
        press(B_CAN, "pr.cancel");

        // Held inc counts once
        press(B_MOD, "hold.enter");
        for (int i = 0; i < 100; i++) cyc(B_INC, "hold.inc");
        cyc(4'b0000, "hold.rel");
        chk("hold.h", int'(bus_if.hours_o), 9);

        // Reset mid-edit with mode held across release
        press(B_CAN, "rst.leave");
        press(B_MOD, "rst.enter");
        press(B_MOD, "rst.to_m");
        press(B_MOD, "rst.to_s");
        bus_if.btn_mode = 1'b1;
        s0 = start_cnt;
        #3 reset = 1'b1;
        model_reset();
        #1 check_all("rst.async");
        cyc(B_MOD, "rst.hold");
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc(B_MOD, "rst.held");
        chk("rst.edit", int'(bus_if.edit_active), 0);
        chk("rst.nostart", start_cnt - s0, 0);
        cyc(4'b0000, "rst.release");
        press(B_MOD, "rst.repress");
        chk("rst.reentry_sel", int'(bus_if.field_sel), 1);
        press(B_CAN, "rst.done");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [3:0] b;
            set_cur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            b[3] = ($urandom_range(0, 15) == 0);
            b[2] = ($urandom_range(0, 3) == 0);
            b[1] = ($urandom_range(0, 2) == 0);
            b[0] = ($urandom_range(0, 2) == 0);
            cyc(b, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
